// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the mux_scan_nxw channel selector.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAN  = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    localparam logic MODE_MAN  = 1'b0;
    localparam logic MODE_SCAN = 1'b1;

endpackage

// File: rtl/mux_scan_next_ch.sv
// Next-channel finder for the scan pointer.
// With MUX_SCAN_MASK_EN defined it searches upward from i_ptr for the next
// enabled channel, wrapping at N; otherwise it is a plain wrapping increment.
module mux_scan_next_ch #(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [SEL_W-1:0] i_ptr,
`ifdef MUX_SCAN_MASK_EN
    input  logic [N-1:0]     i_mask,
`endif
    output logic [SEL_W-1:0] o_next
);

`ifdef MUX_SCAN_MASK_EN
    // First enabled channel strictly after i_ptr; i_ptr itself only if it is the sole enabled one.
    always_comb begin
        logic             found;
        logic [SEL_W-1:0] idx;
        found  = 1'b0;
        idx    = '0;
        o_next = '0;
        for (int i = 1; i <= N; i++) begin
            idx = SEL_W'((int'(i_ptr) + i) % N);
            if (!found && i_mask[idx]) begin
                found  = 1'b1;
                o_next = idx;
            end
        end
    end
`else
    // Wrapping increment over 0..N-1.
    always_comb begin
        if (int'(i_ptr) == N - 1) o_next = '0;
        else                      o_next = i_ptr + 1'b1;
    end
`endif

endmodule

// File: rtl/mux_scan_nxw.sv
// N-channel, W-bit multiplexer with registered output and valid/ready handshake.
// Manual mode picks the channel from i_sel; scan mode walks a pointer through
// the channels, emitting one word every DWELL cycles.
// Optional feature macro: MUX_SCAN_MASK_EN (adds i_mask channel-enable port).
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | first cycle after reset, picks MAN or SCAN from i_mode
// ST_MAN  | capture i_sel's channel on every free output slot
// ST_SCAN | dwell on r_ptr for DWELL cycles, then capture and advance
module mux_scan_nxw
    import mux_scan_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int W     = 1,
    parameter  int DWELL = 4,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N*W-1:0]   i_e,
    input  logic [SEL_W-1:0] i_sel,
    input  logic             i_mode,
    input  logic             i_y_ready,
`ifdef MUX_SCAN_MASK_EN
    input  logic [N-1:0]     i_mask,
`endif
    output logic [W-1:0]     o_y,
    output logic [SEL_W-1:0] o_y_ch,
    output logic             o_y_valid,
    output logic             o_err
);

    localparam int             CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_t           r_state, w_state_nxt;
    logic [SEL_W-1:0] r_ptr, w_ptr_nxt, w_ptr_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [W-1:0]     r_y, w_y_nxt;
    logic [SEL_W-1:0] r_y_ch, w_y_ch_nxt;
    logic             r_y_valid, w_y_valid_nxt;
    logic             r_err, w_err_nxt;

    logic             w_slot_free;
    logic             w_any_en;
    logic             w_sel_ok, w_ptr_ok;
    logic [W-1:0]     w_sel_data, w_ptr_data;

    assign w_slot_free = !r_y_valid || i_y_ready;

`ifdef MUX_SCAN_MASK_EN
    assign w_any_en = |i_mask;

    mux_scan_next_ch #(.N(N), .SEL_W(SEL_W)) u_next_ch (
        .i_ptr  (r_ptr),
        .i_mask (i_mask),
        .o_next (w_ptr_next)
    );
`else
    assign w_any_en = 1'b1;

    mux_scan_next_ch #(.N(N), .SEL_W(SEL_W)) u_next_ch (
        .i_ptr  (r_ptr),
        .o_next (w_ptr_next)
    );
`endif

    // Channel muxes for the manual select and the scan pointer; *_ok is low for out-of-range or disabled channels.
    always_comb begin
        w_sel_ok   = 1'b0;
        w_sel_data = '0;
        w_ptr_ok   = 1'b0;
        w_ptr_data = '0;
        for (int k = 0; k < N; k++) begin
            if (i_sel == SEL_W'(k)) begin
                w_sel_data = i_e[k*W +: W];
`ifdef MUX_SCAN_MASK_EN
                w_sel_ok   = i_mask[k];
`else
                w_sel_ok   = 1'b1;
`endif
            end
            if (r_ptr == SEL_W'(k)) begin
                w_ptr_data = i_e[k*W +: W];
`ifdef MUX_SCAN_MASK_EN
                w_ptr_ok   = i_mask[k];
`else
                w_ptr_ok   = 1'b1;
`endif
            end
        end
    end

    // Next-state, pointer, dwell counter and output-slot logic.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_cnt_nxt     = r_cnt;
        w_y_nxt       = r_y;
        w_y_ch_nxt    = r_y_ch;
        // A free slot with no capture means the held word (if any) was taken.
        w_y_valid_nxt = w_slot_free ? 1'b0 : r_y_valid;
        w_err_nxt     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_mode == MODE_SCAN) begin
                    w_state_nxt = ST_SCAN;
                    w_ptr_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = ST_MAN;
                end
            end
            ST_MAN: begin
                if (!w_sel_ok) begin
                    w_err_nxt = 1'b1;
                end else if (w_slot_free) begin
                    w_y_nxt       = w_sel_data;
                    w_y_ch_nxt    = i_sel;
                    w_y_valid_nxt = 1'b1;
                end
                if (i_mode == MODE_SCAN) begin
                    w_state_nxt = ST_SCAN;
                    w_ptr_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
            ST_SCAN: begin
                if (!w_any_en) begin
                    w_ptr_nxt = '0;
                    w_cnt_nxt = '0;
                end else if (r_cnt != CNT_LAST) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end else if (!w_ptr_ok) begin
                    // Pointer parked on a channel that was disabled under it: skip without emitting.
                    w_ptr_nxt = w_ptr_next;
                    w_cnt_nxt = '0;
                end else if (w_slot_free) begin
                    w_y_nxt       = w_ptr_data;
                    w_y_ch_nxt    = r_ptr;
                    w_y_valid_nxt = 1'b1;
                    w_ptr_nxt     = w_ptr_next;
                    w_cnt_nxt     = '0;
                end
                if (i_mode == MODE_MAN) w_state_nxt = ST_MAN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Pointer, dwell counter and output register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_y       <= '0;
            r_y_ch    <= '0;
            r_y_valid <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_ptr     <= w_ptr_nxt;
            r_cnt     <= w_cnt_nxt;
            r_y       <= w_y_nxt;
            r_y_ch    <= w_y_ch_nxt;
            r_y_valid <= w_y_valid_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign o_y       = r_y;
    assign o_y_ch    = r_y_ch;
    assign o_y_valid = r_y_valid;
    assign o_err     = r_err;

endmodule

// File: tb/tb_mux_scan_nxw.sv
// Testbench for mux_scan_nxw: directed tables and sequences on an N=4/W=1
// instance, error and randomized model comparison on an N=5/W=3 instance.
`timescale 1ns/1ps
module tb_mux_scan_nxw;

    localparam int N0 = 4, W0 = 1, D0 = 4, S0 = 2;
    localparam int N1 = 5, W1 = 3, D1 = 3, S1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst0_n, mode0, rdy0;
    logic [N0*W0-1:0]  e0;
    logic [S0-1:0]     sel0;
    logic [W0-1:0]     y0;
    logic [S0-1:0]     ych0;
    logic              v0, err0;

    logic              rst1_n, mode1, rdy1;
    logic [N1*W1-1:0]  e1;
    logic [S1-1:0]     sel1;
    logic [W1-1:0]     y1;
    logic [S1-1:0]     ych1;
    logic              v1, err1;

`ifdef MUX_SCAN_MASK_EN
    logic [N0-1:0] mask0;
    logic [N1-1:0] mask1;
`endif

    mux_scan_nxw #(.N(N0), .W(W0), .DWELL(D0)) u_dut0 (
        .i_clk     (clk),
        .i_rst_n   (rst0_n),
        .i_e       (e0),
        .i_sel     (sel0),
        .i_mode    (mode0),
        .i_y_ready (rdy0),
`ifdef MUX_SCAN_MASK_EN
        .i_mask    (mask0),
`endif
        .o_y       (y0),
        .o_y_ch    (ych0),
        .o_y_valid (v0),
        .o_err     (err0)
    );

    mux_scan_nxw #(.N(N1), .W(W1), .DWELL(D1)) u_dut1 (
        .i_clk     (clk),
        .i_rst_n   (rst1_n),
        .i_e       (e1),
        .i_sel     (sel1),
        .i_mode    (mode1),
        .i_y_ready (rdy1),
`ifdef MUX_SCAN_MASK_EN
        .i_mask    (mask1),
`endif
        .o_y       (y1),
        .o_y_ch    (ych1),
        .o_y_valid (v1),
        .o_err     (err1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference for the N=5 instance: one call per clock edge,
    // using the inputs currently applied.
    int          m_mode_st;   // 0 = just out of reset, 1 = manual, 2 = scanning
    int          m_pos;       // scan channel currently being dwelt on
    int          m_age;       // cycles already spent on m_pos
    int          m_y, m_ch;
    bit          m_v, m_err;

    function automatic int chan1(input logic [N1*W1-1:0] e, input int k);
        return int'(e[k*W1 +: W1]);
    endfunction

    task automatic model_reset();
        m_mode_st = 0; m_pos = 0; m_age = 0;
        m_y = 0; m_ch = 0; m_v = 0; m_err = 0;
    endtask

    task automatic model_step();
        bit take = !m_v || (rdy1 == 1'b1);
        bit emit = 0;
        int src  = 0;
        int nst  = m_mode_st;
        m_err = 0;
        if (m_mode_st == 0) begin
            nst = mode1 ? 2 : 1;
            m_pos = 0; m_age = 0;
        end else if (m_mode_st == 1) begin
            if (int'(sel1) >= N1) m_err = 1;
            else if (take) begin emit = 1; src = int'(sel1); end
            if (mode1) begin nst = 2; m_pos = 0; m_age = 0; end
        end else begin
            if (m_age + 1 < D1) m_age++;
            else if (take) begin
                emit = 1; src = m_pos;
                m_pos = (m_pos + 1) % N1;
                m_age = 0;
            end
            if (!mode1) nst = 1;
        end
        if (take) begin
            m_v = emit;
            if (emit) begin m_y = chan1(e1, src); m_ch = src; end
        end
        m_mode_st = nst;
    endtask

    typedef struct {
        int sel;
        bit rdy;
        int y;
        int ch;
        int v;
    } vec_t;

    vec_t vt[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int got_ch[$];
        int exp_mask_seq[4];
        int cnt_v;
        int budget;

        // E=1010: channels 0..3 carry 0,1,0,1
        vt[0] = '{0, 1'b1, 0, 0, 1};
        vt[1] = '{1, 1'b1, 1, 1, 1};
        vt[2] = '{2, 1'b1, 0, 2, 1};
        vt[3] = '{3, 1'b1, 1, 3, 1};
        vt[4] = '{2, 1'b0, 1, 3, 1};
        vt[5] = '{0, 1'b0, 1, 3, 1};
        vt[6] = '{1, 1'b1, 1, 1, 1};
        vt[7] = '{0, 1'b1, 0, 0, 1};

        rst0_n = 1'b0; mode0 = 1'b0; rdy0 = 1'b1; e0 = 4'b1010; sel0 = '0;
        rst1_n = 1'b0; mode1 = 1'b0; rdy1 = 1'b1; e1 = '0; sel1 = '0;
`ifdef MUX_SCAN_MASK_EN
        mask0 = '1;
        mask1 = '1;
`endif
        #2;
        chk("reset_y",     int'(y0),   0);
        chk("reset_ych",   int'(ych0), 0);
        chk("reset_valid", int'(v0),   0);
        chk("reset_err",   int'(err0), 0);
        tick();
        rst0_n = 1'b1;
        rst1_n = 1'b1;
        tick();
        chk("idle_no_valid", int'(v0), 0);

        // Manual table
        for (int i = 0; i < 8; i++) begin
            sel0 = vt[i].sel[S0-1:0];
            rdy0 = vt[i].rdy;
            tick();
            chk($sformatf("man[%0d]_y", i),     int'(y0),   vt[i].y);
            chk($sformatf("man[%0d]_ch", i),    int'(ych0), vt[i].ch);
            chk($sformatf("man[%0d]_valid", i), int'(v0),   vt[i].v);
        end

        // Scan: one word every D0 cycles, channel order 0,1,2,3,0
        rdy0 = 1'b1;
        mode0 = 1'b1;
        tick();
        for (int wd = 0; wd < 5; wd++) begin
            for (int c = 0; c < D0; c++) begin
                tick();
                if (c < D0 - 1) begin
                    chk($sformatf("scan[%0d]_idle%0d", wd, c), int'(v0), 0);
                end else begin
                    chk($sformatf("scan[%0d]_valid", wd), int'(v0),   1);
                    chk($sformatf("scan[%0d]_ch", wd),    int'(ych0), wd % N0);
                    chk($sformatf("scan[%0d]_y", wd),     int'(y0),   (wd % N0) & 1);
                end
            end
        end

        // Backpressure at a capture point: word ch0 held, pointer not advanced
        rdy0 = 1'b0;
        for (int c = 0; c < D0 - 1 + 10; c++) begin
            tick();
            chk($sformatf("bp[%0d]_ch", c),    int'(ych0), 0);
            chk($sformatf("bp[%0d]_valid", c), int'(v0),   1);
            chk($sformatf("bp[%0d]_y", c),     int'(y0),   0);
        end
        e0 = 4'b0101;
        rdy0 = 1'b1;
        tick();
        chk("bp_release_valid", int'(v0),   1);
        chk("bp_release_ch",    int'(ych0), 1);
        chk("bp_release_y",     int'(y0),   0);
        for (int c = 0; c < D0; c++) begin
            tick();
            if (c < D0 - 1) chk($sformatf("bp_after_idle%0d", c), int'(v0), 0);
        end
        chk("bp_after_ch",    int'(ych0), 2);
        chk("bp_after_valid", int'(v0),   1);
        chk("bp_after_y",     int'(y0),   1);

        // Asynchronous reset in the middle of a stall
        rdy0 = 1'b0;
        tick();
        tick();
        #2;
        rst0_n = 1'b0;
        #1;
        chk("async_rst_y",     int'(y0),   0);
        chk("async_rst_ch",    int'(ych0), 0);
        chk("async_rst_valid", int'(v0),   0);
        chk("async_rst_err",   int'(err0), 0);
        tick();
        tick();
        chk("rst_held_valid", int'(v0), 0);

`ifdef MUX_SCAN_MASK_EN
        // Masked scan: only channels 0 and 2
        mask0 = 4'b0101;
        mode0 = 1'b1;
        rdy0  = 1'b1;
        rst0_n = 1'b1;
        exp_mask_seq = '{0, 2, 0, 2};
        budget = 0;
        while (got_ch.size() < 4 && budget < 80) begin
            tick();
            budget++;
            if (v0) got_ch.push_back(int'(ych0));
        end
        chk("mask_word_count", got_ch.size(), 4);
        for (int i = 0; i < got_ch.size() && i < 4; i++)
            chk($sformatf("mask_seq[%0d]", i), got_ch[i], exp_mask_seq[i]);
        mask0 = '0;
        cnt_v = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (v0) cnt_v++;
        end
        chk("mask_zero_no_valid", cnt_v, 0);
`endif

        // N=5: illegal manual select
        e1 = 15'($urandom);
        sel1 = 3'd2;
        tick();
        chk("n5_sel2_valid", int'(v1),   1);
        chk("n5_sel2_ch",    int'(ych1), 2);
        chk("n5_sel2_y",     int'(y1),   chan1(e1, 2));
        chk("n5_sel2_err",   int'(err1), 0);
        sel1 = 3'd7;
        tick();
        chk("n5_sel7_err",   int'(err1), 1);
        chk("n5_sel7_valid", int'(v1),   0);
        chk("n5_sel7_ch",    int'(ych1), 2);
        chk("n5_sel7_y",     int'(y1),   chan1(e1, 2));
        sel1 = 3'd3;
        tick();
        chk("n5_sel3_err",   int'(err1), 0);
        chk("n5_sel3_valid", int'(v1),   1);
        chk("n5_sel3_ch",    int'(ych1), 3);

        // Randomized run against the reference model
        rst1_n = 1'b0;
        mode1 = 1'b0;
        tick();
        rst1_n = 1'b1;
        model_reset();
        for (int c = 0; c < 600; c++) begin
            e1   = 15'($urandom);
            sel1 = 3'($urandom_range(0, 7));
            rdy1 = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 24) == 0) mode1 = ~mode1;
            model_step();
            tick();
            chk($sformatf("rnd[%0d]_valid", c), int'(v1),   int'(m_v));
            chk($sformatf("rnd[%0d]_y", c),     int'(y1),   m_y);
            chk($sformatf("rnd[%0d]_ch", c),    int'(ych1), m_ch);
            chk($sformatf("rnd[%0d]_err", c),   int'(err1), int'(m_err));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
